// File: rtl/sound_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sound_pkg                                                   |
// | Brief  : Shared constants, state encodings and helpers for the song  |
// |          sequencer and its per-voice sub-sequencers.                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package sound_pkg;

    // Library tick value marking the end of a song (sliced to TICKS_W by users)
    localparam logic [31:0] END_TICKS = '1;

    // Smallest usable beat length in clocks; lower tempo inputs are clamped
    localparam int TEMPO_MIN = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } topState_t;

    typedef enum logic [2:0] {
        V_IDLE = 3'd0,
        FETCH  = 3'd1,
        LATCH  = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } voiceState_t;

    // Duration code d means 2^d beats (1..128)
    function automatic logic [7:0] decodeDuration(input logic [2:0] code);
        return 8'd1 << code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/voice_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : voice_sequencer                                             |
// | Brief  : One voice: steps through its library, holds each note for   |
// |          2^duration beats and keeps a held copy for pause/resume.    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module voice_sequencer
    import sound_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TICKS_W = 18
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [1:0]         song,
    input  logic               start,
    input  logic               halt,
    input  logic               run,
    input  logic               beat,
    input  logic               mute,
    input  logic               resume,
    input  logic [2:0]         romDuration,
    input  logic [TICKS_W-1:0] romTicks,
    output logic [ADDR_W-1:0]  addr,
    output logic [TICKS_W-1:0] ticksOut,
    output logic               done
);

    localparam int                 IDX_W      = ADDR_W - 2;
    localparam logic [IDX_W-1:0]   c_idxMax   = '1;
    localparam logic [TICKS_W-1:0] c_endTicks = END_TICKS[TICKS_W-1:0];

    voiceState_t        r_state;
    logic [IDX_W-1:0]   r_index;
    logic [7:0]         r_remain;
    logic [TICKS_W-1:0] r_held;
    logic [TICKS_W-1:0] r_ticksOut;

    assign addr     = {song, r_index};
    assign ticksOut = r_ticksOut;
    assign done     = (r_state == DONE);

    // Voice FSM; mute/resume are applied last so they override the audible value
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= V_IDLE;
            r_index    <= '0;
            r_remain   <= '0;
            r_held     <= '0;
            r_ticksOut <= '0;
        end else if (halt) begin
            r_state    <= V_IDLE;
            r_index    <= '0;
            r_remain   <= '0;
            r_held     <= '0;
            r_ticksOut <= '0;
        end else begin
            if (start) begin
                r_state <= FETCH;
                r_index <= '0;
            end else if (run) begin
                case (r_state)
                    FETCH: r_state <= LATCH;
                    LATCH: begin
                        if (romTicks == c_endTicks) begin
                            r_state    <= DONE;
                            r_held     <= '0;
                            r_ticksOut <= '0;
                        end else begin
                            r_state    <= HOLD;
                            r_held     <= romTicks;
                            r_ticksOut <= romTicks;
                            r_remain   <= decodeDuration(romDuration);
                        end
                    end
                    HOLD: begin
                        if (beat) begin
                            if (r_remain == 8'd1) begin
                                // Last library slot acts as an implicit END
                                if (r_index == c_idxMax) begin
                                    r_state    <= DONE;
                                    r_held     <= '0;
                                    r_ticksOut <= '0;
                                end else begin
                                    r_index <= r_index + IDX_W'(1);
                                    r_state <= FETCH;
                                end
                            end else begin
                                r_remain <= r_remain - 8'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            if (mute) begin
                r_ticksOut <= '0;
            end else if (resume) begin
                r_ticksOut <= r_held;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/song_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : song_sequencer                                              |
// | Brief  : Transport/tempo controller sequencing melody and bass       |
// |          voices through the note libraries with play/pause/stop.     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module song_sequencer
    import sound_pkg::*;
#(
    parameter int TEMPO_W = 24,
    parameter int ADDR_W  = 8,
    parameter int TICKS_W = 18
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               play,
    input  logic               pause,
    input  logic               stop,
    input  logic [1:0]         song_sel,
    input  logic               loop_en,
    input  logic [TEMPO_W-1:0] tempo,
    output logic [ADDR_W-1:0]  mel_addr,
    input  logic [2:0]         mel_duration,
    input  logic [TICKS_W-1:0] mel_ticks,
    output logic [ADDR_W-1:0]  bass_addr,
    input  logic [2:0]         bass_duration,
    input  logic [TICKS_W-1:0] bass_ticks,
    output logic [TICKS_W-1:0] mel_ticks_out,
    output logic [TICKS_W-1:0] bass_ticks_out,
    output logic               playing,
    output logic               paused,
    output logic               song_done
);

    topState_t          r_state;
    logic [1:0]         r_song;
    logic [TEMPO_W-1:0] r_beatCnt;
    logic               r_playing;
    logic               r_paused;
    logic               r_songDone;

    logic [TEMPO_W-1:0] w_term;
    logic               w_inIdle, w_inPlay, w_inPause;
    logic               w_melDone, w_bassDone, w_bothDone;
    logic               w_loop, w_finish, w_start, w_halt, w_mute, w_resume, w_beat;

    assign playing   = r_playing;
    assign paused    = r_paused;
    assign song_done = r_songDone;

    // Command arbitration (stop > pause > play) and voice control strobes
    always_comb begin
        w_term     = (tempo < TEMPO_W'(TEMPO_MIN)) ? TEMPO_W'(TEMPO_MIN - 1)
                                                   : tempo - TEMPO_W'(1);
        w_inIdle   = (r_state == IDLE);
        w_inPlay   = (r_state == PLAY);
        w_inPause  = (r_state == PAUSE);
        w_bothDone = w_melDone & w_bassDone;
        w_loop     = w_inPlay & ~stop & ~pause & w_bothDone & loop_en;
        w_finish   = w_inPlay & ~stop & ~pause & w_bothDone & ~loop_en;
        w_start    = (w_inIdle & ~stop & play) | w_loop;
        w_halt     = stop | w_finish;
        w_mute     = w_inPlay & ~stop & pause;
        w_resume   = w_inPause & ~stop & play;
        w_beat     = w_inPlay & (r_beatCnt == w_term);
    end

    // Top transport FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= IDLE;
            r_song     <= '0;
            r_playing  <= 1'b0;
            r_paused   <= 1'b0;
            r_songDone <= 1'b0;
        end else begin
            r_songDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!stop && play) begin
                        r_state   <= PLAY;
                        r_song    <= song_sel;
                        r_playing <= 1'b1;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        r_state   <= IDLE;
                        r_playing <= 1'b0;
                    end else if (pause) begin
                        r_state   <= PAUSE;
                        r_playing <= 1'b0;
                        r_paused  <= 1'b1;
                    end else if (w_finish) begin
                        r_state    <= IDLE;
                        r_playing  <= 1'b0;
                        r_songDone <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        r_state  <= IDLE;
                        r_paused <= 1'b0;
                    end else if (play) begin
                        r_state   <= PLAY;
                        r_paused  <= 1'b0;
                        r_playing <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_playing <= 1'b0;
                    r_paused  <= 1'b0;
                end
            endcase
        end
    end

    // Beat counter: runs in PLAY, holds in PAUSE, wraps if tempo shrank below it
    always_ff @(posedge clk) begin
        if (clr) begin
            r_beatCnt <= '0;
        end else if (stop || w_inIdle) begin
            r_beatCnt <= '0;
        end else if (w_inPlay) begin
            r_beatCnt <= (r_beatCnt >= w_term) ? '0 : r_beatCnt + TEMPO_W'(1);
        end
    end

    voice_sequencer #(
        .ADDR_W  (ADDR_W),
        .TICKS_W (TICKS_W)
    ) u_melody (
        .clk         (clk),
        .clr         (clr),
        .song        (r_song),
        .start       (w_start),
        .halt        (w_halt),
        .run         (w_inPlay),
        .beat        (w_beat),
        .mute        (w_mute),
        .resume      (w_resume),
        .romDuration (mel_duration),
        .romTicks    (mel_ticks),
        .addr        (mel_addr),
        .ticksOut    (mel_ticks_out),
        .done        (w_melDone)
    );

    voice_sequencer #(
        .ADDR_W  (ADDR_W),
        .TICKS_W (TICKS_W)
    ) u_bass (
        .clk         (clk),
        .clr         (clr),
        .song        (r_song),
        .start       (w_start),
        .halt        (w_halt),
        .run         (w_inPlay),
        .beat        (w_beat),
        .mute        (w_mute),
        .resume      (w_resume),
        .romDuration (bass_duration),
        .romTicks    (bass_ticks),
        .addr        (bass_addr),
        .ticksOut    (bass_ticks_out),
        .done        (w_bassDone)
    );

endmodule
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_song_sequencer                                           |
// | Brief  : Directed self-checking bench for song_sequencer with        |
// |          registered library ROM models for both voices.              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_song_sequencer;

    logic        clk = 1'b0;
    logic        clr, play, pause, stop, loop_en;
    logic [1:0]  song_sel;
    logic [23:0] tempo;
    logic [7:0]  mel_addr, bass_addr;
    logic [2:0]  mel_duration, bass_duration;
    logic [17:0] mel_ticks, bass_ticks;
    logic [17:0] mel_ticks_out, bass_ticks_out;
    logic        playing, paused, song_done;

    logic [17:0] melT [256];
    logic [2:0]  melD [256];
    logic [17:0] bassT [256];
    logic [2:0]  bassD [256];

    int nVec = 0;
    int nMis = 0;
    int rel  = 0;
    bit sawDone = 1'b0;

    always #5 clk = ~clk;

    song_sequencer dut (
        .clk            (clk),
        .clr            (clr),
        .play           (play),
        .pause          (pause),
        .stop           (stop),
        .song_sel       (song_sel),
        .loop_en        (loop_en),
        .tempo          (tempo),
        .mel_addr       (mel_addr),
        .mel_duration   (mel_duration),
        .mel_ticks      (mel_ticks),
        .bass_addr      (bass_addr),
        .bass_duration  (bass_duration),
        .bass_ticks     (bass_ticks),
        .mel_ticks_out  (mel_ticks_out),
        .bass_ticks_out (bass_ticks_out),
        .playing        (playing),
        .paused         (paused),
        .song_done      (song_done)
    );

    // Registered library ROMs, one cycle of latency
    always @(posedge clk) begin
        mel_ticks     <= melT[mel_addr];
        mel_duration  <= melD[mel_addr];
        bass_ticks    <= bassT[bass_addr];
        bass_duration <= bassD[bass_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic advanceTo(input int target);
        while (rel < target) begin
            @(posedge clk);
            #1;
            rel++;
            sawDone |= song_done;
        end
    endtask

    task automatic cmd(input logic p, input logic pa, input logic s);
        play  = p;
        pause = pa;
        stop  = s;
        @(posedge clk);
        #1;
        rel++;
        sawDone |= song_done;
        play  = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) begin
            melT[a]  = 18'h3FFFF;
            melD[a]  = 3'd0;
            bassT[a] = 18'h3FFFF;
            bassD[a] = 3'd0;
        end
        // song 1
        melT[8'h40] = 18'd1000; melD[8'h40] = 3'd1;
        melT[8'h41] = 18'd2000; melD[8'h41] = 3'd0;
        // song 2
        melT[8'h80]  = 18'd3000; melD[8'h80]  = 3'd2;
        bassT[8'h80] = 18'd500;  bassD[8'h80] = 3'd3;
        // song 3
        melT[8'hC0]  = 18'd700;  melD[8'hC0]  = 3'd1;
        melT[8'hC1]  = 18'd0;    melD[8'hC1]  = 3'd1;
        bassT[8'hC0] = 18'd90;   bassD[8'hC0] = 3'd0;

        clr = 1'b1; play = 1'b0; pause = 1'b0; stop = 1'b0;
        song_sel = 2'd0; loop_en = 1'b0; tempo = 24'd4;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        check("rst_playing", playing, 0);
        check("rst_paused", paused, 0);
        check("rst_done", song_done, 0);
        check("rst_mel_out", mel_ticks_out, 0);
        check("rst_bass_out", bass_ticks_out, 0);
        check("rst_mel_addr", mel_addr, 0);
        check("rst_bass_addr", bass_addr, 0);

        // Basic play, song 1, tempo 4
        song_sel = 2'd1; rel = 0;
        cmd(1, 0, 0);
        check("basic_playing", playing, 1);
        check("basic_mel_addr", mel_addr, 8'h40);
        check("basic_bass_addr", bass_addr, 8'h40);
        advanceTo(2);  check("basic_mel_n2", mel_ticks_out, 0);
        advanceTo(3);  check("basic_mel_n3", mel_ticks_out, 1000);
                       check("basic_bass_n3", bass_ticks_out, 0);
        advanceTo(10); check("basic_mel_n10", mel_ticks_out, 1000);
        advanceTo(11); check("basic_mel_n11", mel_ticks_out, 2000);
        advanceTo(14); check("basic_mel_n14", mel_ticks_out, 2000);
        advanceTo(15); check("basic_mel_n15", mel_ticks_out, 0);
                       check("basic_done_n15", song_done, 0);
        advanceTo(16); check("basic_done_n16", song_done, 1);
                       check("basic_playing_n16", playing, 0);
        advanceTo(17); check("basic_done_n17", song_done, 0);
        advanceTo(20);

        // Tempo below minimum behaves as 4
        tempo = 24'd1; rel = 0;
        cmd(1, 0, 0);
        advanceTo(3);  check("clamp_mel_n3", mel_ticks_out, 1000);
        advanceTo(10); check("clamp_mel_n10", mel_ticks_out, 1000);
        advanceTo(11); check("clamp_mel_n11", mel_ticks_out, 2000);
        advanceTo(16); check("clamp_done_n16", song_done, 1);
        advanceTo(20);

        // Pause mid-note for 51 cycles, then resume
        tempo = 24'd4; song_sel = 2'd2; rel = 0;
        cmd(1, 0, 0);
        advanceTo(9);
        cmd(0, 1, 0);
        check("pause_paused", paused, 1);
        check("pause_playing", playing, 0);
        check("pause_mel_mute", mel_ticks_out, 0);
        check("pause_bass_mute", bass_ticks_out, 0);
        advanceTo(60);
        check("pause_mel_hold", mel_ticks_out, 0);
        check("pause_still", paused, 1);
        cmd(1, 0, 0);
        check("resume_mel", mel_ticks_out, 3000);
        check("resume_bass", bass_ticks_out, 500);
        check("resume_playing", playing, 1);
        advanceTo(69); check("resume_mel_n69", mel_ticks_out, 3000);
        advanceTo(70); check("resume_mel_n70", mel_ticks_out, 0);
                       check("resume_bass_n70", bass_ticks_out, 500);
        advanceTo(85); check("resume_bass_n85", bass_ticks_out, 500);
        advanceTo(86); check("resume_bass_n86", bass_ticks_out, 0);
        advanceTo(87); check("resume_done_n87", song_done, 1);
        advanceTo(90);

        // Stop beats play in the same cycle
        rel = 0;
        cmd(1, 0, 0);
        advanceTo(5); check("stop_mel_before", mel_ticks_out, 3000);
        cmd(1, 0, 1);
        check("stop_playing", playing, 0);
        check("stop_mel_out", mel_ticks_out, 0);
        check("stop_bass_out", bass_ticks_out, 0);
        advanceTo(12);
        check("stop_no_restart", playing, 0);
        check("stop_mel_index", mel_addr[5:0], 0);
        check("stop_mel_quiet", mel_ticks_out, 0);

        // Looping with bass ending first
        song_sel = 2'd3; loop_en = 1'b1; rel = 0; sawDone = 1'b0;
        cmd(1, 0, 0);
        advanceTo(3);  check("loop_mel_n3", mel_ticks_out, 700);
                       check("loop_bass_n3", bass_ticks_out, 90);
        advanceTo(7);  check("loop_bass_n7", bass_ticks_out, 0);
                       check("loop_mel_n7", mel_ticks_out, 700);
        advanceTo(11); check("loop_mel_rest", mel_ticks_out, 0);
        advanceTo(19); check("loop_mel_addr_n19", mel_addr, 8'hC2);
                       check("loop_bass_addr_n19", bass_addr, 8'hC1);
        advanceTo(20); check("loop_mel_addr_n20", mel_addr, 8'hC0);
                       check("loop_bass_addr_n20", bass_addr, 8'hC0);
                       check("loop_playing", playing, 1);
        advanceTo(22); check("loop_mel_n22", mel_ticks_out, 700);
                       check("loop_bass_n22", bass_ticks_out, 90);
        check("loop_no_done", sawDone, 0);
        cmd(0, 0, 1);
        loop_en = 1'b0;
        advanceTo(30);

        // Tempo drop below the running count forces a wrap
        song_sel = 2'd2; tempo = 24'd10; rel = 0;
        cmd(1, 0, 0);
        advanceTo(3);  check("tempo_mel_n3", mel_ticks_out, 3000);
        advanceTo(9);
        tempo = 24'd6;
        advanceTo(35); check("tempo_mel_n35", mel_ticks_out, 3000);
        advanceTo(36); check("tempo_mel_n36", mel_ticks_out, 0);
        cmd(0, 0, 1);
        tempo = 24'd4;
        advanceTo(40);

        // Reset held three cycles during PLAY
        song_sel = 2'd1; rel = 0;
        cmd(1, 0, 0);
        advanceTo(5); check("mid_mel_before", mel_ticks_out, 1000);
        clr = 1'b1;
        advanceTo(8);
        clr = 1'b0;
        check("mid_rst_playing", playing, 0);
        check("mid_rst_paused", paused, 0);
        check("mid_rst_mel_out", mel_ticks_out, 0);
        check("mid_rst_bass_out", bass_ticks_out, 0);
        check("mid_rst_mel_addr", mel_addr, 0);
        check("mid_rst_bass_addr", bass_addr, 0);
        advanceTo(9);
        check("mid_rst_idle", playing, 0);
        check("mid_rst_done", song_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Transport and tempo controller that sequences two voices (melody, bass) through a song stored in the note libraries.
- Handles play/pause/stop commands, song selection, tempo, per-note durations, end-of-song and looping.
- Sits between user-control debouncers and the library ROMs; its output tick values feed the two sound_generator instances.
- Replaces the free-running pulse generator and duration FSM pair with one arbitrated, pausable sequencer.

Parameters:
TEMPO_W, 24, width of the tempo (clocks per beat unit) input
ADDR_W, 8, library address width; upper 2 bits = song, lower ADDR_W-2 bits = note index
TICKS_W, 18, width of a note's half-period tick count

Ports:
clk  in  1  system clock
clr  in  1  reset; synchronous, active-high
play  in  1  single-cycle pulse; start from IDLE, resume from PAUSE
pause  in  1  single-cycle pulse; PLAY->PAUSE
stop  in  1  single-cycle pulse; any state->IDLE
song_sel  in  2  song number, latched only on play accepted in IDLE
loop_en  in  1  sampled when both voices reach end-of-song
tempo  in  TEMPO_W  clocks per beat unit; values below 4 are treated as 4
mel_addr  out  ADDR_W  melody library address {song, index}
mel_duration  in  3  duration code at mel_addr (ROM registered, 1-cycle latency)
mel_ticks  in  TICKS_W  tick value at mel_addr; 0 = rest; all-ones = END marker
bass_addr, bass_duration, bass_ticks: same as the three mel_* ports, for the bass voice
mel_ticks_out  out  TICKS_W  to melody sound_generator; 0 = silent
bass_ticks_out  out  TICKS_W  to bass sound_generator; 0 = silent
playing  out  1  high in PLAY
paused  out  1  high in PAUSE
song_done  out  1  one-cycle pulse when a non-looping song ends

Behaviour:
- Reset (clr): top state IDLE; voice states IDLE; indices 0; addresses 0; all ticks_out 0; playing, paused and song_done 0; beat counter 0. clr overrides every other input.
- Top FSM:
  - IDLE + play: latch song_sel, indices = 0, beat counter = 0, both voices enter FETCH, go to PLAY.
  - PLAY + pause: go to PAUSE.
  - PAUSE + play: return to PLAY.
  - Any state + stop: go to IDLE, ticks_out = 0, indices = 0.
  - Priority: stop > pause > play. play in PLAY, and pause in IDLE or PAUSE, are ignored.
- Beat counter: counts 0..max(tempo,4)-1 only in PLAY. beat is a 1-cycle strobe on the terminal count. The counter holds its value in PAUSE and clears in IDLE. A tempo change takes effect at the next compare; if the count already exceeds the new terminal value, it wraps to 0 on the next cycle.
- Voice FSM (one per voice):
  - FETCH: addr = {song, index} for 1 cycle.
  - LATCH: ROM data valid.
    - mel_ticks/bass_ticks == all-ones: ticks_out = 0, go to DONE.
    - Otherwise: ticks_out = ticks; remain = 2^duration (1..128); go to HOLD.
  - HOLD: each beat decrements remain. On the beat where remain == 1: index += 1, go to FETCH.
- ticks_out keeps the previous note through FETCH and LATCH (no glitch). Beats during FETCH or LATCH are not counted by that voice.
- Index reaching its maximum value without an END marker: the voice treats the next step as END and does not wrap.
- Both voices in DONE:
  - loop_en = 1: indices = 0, both voices go to FETCH in the next cycle, beat counter is not reset.
  - loop_en = 0: song_done pulses for 1 cycle and the top state goes to IDLE.
  - One voice DONE early: it stays silent while the other voice finishes.
- PAUSE: voice states, remain counters and addresses are frozen; ticks_out = 0 (silence). On resume, ticks_out is restored from a held copy in the cycle PLAY is re-entered.
- Latency:
  - play sampled at cycle N: playing = 1 and addr = {song,0} at N+1; ticks_out valid at N+3.
  - stop at N: ticks_out = 0 and playing = 0 at N+1.
- Note length = 2^d beats plus ≤2 cycles of fetch overhead.

Decomposition:
- Shared package sound_pkg holds:
  - END_TICKS (all-ones) constant and TEMPO_MIN = 4
  - top-state enum {IDLE, PLAY, PAUSE}
  - voice-state enum {V_IDLE, FETCH, LATCH, HOLD, DONE}
  - duration decode function (code -> 2^code)
- Sub-module voice_sequencer: one voice's FSM, index, remain counter and held ticks. It is instantiated twice (melody, bass) and driven by shared beat/run/restart strobes from the top.

Test Plan:
- Reset: hold clr 3 cycles mid-PLAY -> all outputs 0 and addresses 0 the cycle after release.
- Basic play: tempo = 4, song 1, melody ROM {ticks 1000 d=1; ticks 2000 d=0; END}, play at N -> mel_addr = 0x40 at N+1, mel_ticks_out = 1000 at N+3, then 2000 after 2 beats, then 0. No loop, so song_done pulses once and playing drops.
- Pause: pause during HOLD -> ticks_out = 0 and remain frozen for 50 cycles; play -> same note resumes and completes its remaining beats exactly.
- Stop priority: stop and play in the same cycle while in PLAY -> IDLE next cycle, ticks_out = 0, no restart.
- Looping: loop_en = 1, bass END earlier than melody -> bass silent until melody END, then both addresses return to index 0 together, and song_done is never asserted.
- Tempo clamp: tempo = 1 -> beat strobe every 4 cycles; change tempo 10 -> 6 while count = 8 -> counter wraps to 0 next cycle.
